// File: rtl/main_fifo_reader_pkg.sv
// Shared definitions for the Main FIFO reader: FSM state encodings and
// the default pop-counter width.
package main_rd_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/main_fifo_reader_if.sv
// Bundle of the Main FIFO read port and the two VC FIFO write ports.
// The master is the reader; the slave is the FIFO side.
interface main_fifo_reader_if #(
  parameter int BW = 6
) ();

  logic          Main_empty;
  logic          Main_error_output;
  logic [BW-1:0] Main_data_out;
  logic          Main_rd;
  logic          VC0_full;
  logic          VC0_almost_full;
  logic          VC1_full;
  logic          VC1_almost_full;
  logic          VC0_wr;
  logic          VC1_wr;
  logic [BW-1:0] vc_data;

  modport master (
    input  Main_empty, Main_error_output, Main_data_out,
    input  VC0_full, VC0_almost_full, VC1_full, VC1_almost_full,
    output Main_rd, VC0_wr, VC1_wr, vc_data
  );

  modport slave (
    output Main_empty, Main_error_output, Main_data_out,
    output VC0_full, VC0_almost_full, VC1_full, VC1_almost_full,
    input  Main_rd, VC0_wr, VC1_wr, vc_data
  );

endinterface

// File: rtl/main_fifo_reader.sv
// Pops the Main ingress FIFO while both VC FIFOs have room and steers each
// word to VC0 or VC1 by its class bit through a two-stage pipeline.
module main_fifo_reader
  import main_rd_pkg::*;
#(
  parameter int BW      = 6,
  parameter int SEL_BIT = BW - 1,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             init,
  main_fifo_reader_if.master bus,
  output logic [2:0]       state,
  output logic             idle,
  output logic             error_out,
  output logic [CNT_W-1:0] pop_count
);

  state_t cur_state;
  state_t next_state;
  logic   s1_valid;
  logic   sel_vc1;
  logic   tgt_full;
  logic   wr_overflow;
  logic   err_cond;
  logic   pipe_busy;

  // Stage 2 decides on the word arriving from the FIFO this cycle.
  assign sel_vc1     = bus.Main_data_out[SEL_BIT];
  assign tgt_full    = sel_vc1 ? bus.VC1_full : bus.VC0_full;
  assign wr_overflow = s1_valid & tgt_full;
  assign err_cond    = bus.Main_error_output | wr_overflow;
  assign pipe_busy   = s1_valid | bus.VC0_wr | bus.VC1_wr;

  // Destination is unknown until the word is read, so both VCs need room.
  assign bus.Main_rd = (cur_state == ST_ACTIVE) & ~bus.Main_empty &
                       ~bus.VC0_almost_full & ~bus.VC1_almost_full;

  assign state     = cur_state;
  assign idle      = (cur_state == ST_IDLE);
  assign error_out = (cur_state == ST_ERROR);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      cur_state <= ST_RESET;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = cur_state;
    if (init) begin
      next_state = ST_INIT;
    end else if (err_cond && (cur_state != ST_RESET) && (cur_state != ST_INIT)) begin
      next_state = ST_ERROR;
    end else begin
      case (cur_state)
        ST_RESET:  next_state = ST_INIT;
        ST_INIT:   next_state = ST_IDLE;
        ST_IDLE:   if (!bus.Main_empty) next_state = ST_ACTIVE;
        ST_ACTIVE: if (bus.Main_empty && !pipe_busy) next_state = ST_IDLE;
        ST_ERROR:  next_state = ST_ERROR;
        default:   next_state = ST_INIT;
      endcase
    end
  end

  // In-flight words finish regardless of state; a write to a full VC is dropped.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      s1_valid    <= 1'b0;
      bus.VC0_wr  <= 1'b0;
      bus.VC1_wr  <= 1'b0;
      bus.vc_data <= '0;
    end else begin
      s1_valid   <= bus.Main_rd;
      bus.VC0_wr <= s1_valid & ~sel_vc1 & ~bus.VC0_full;
      bus.VC1_wr <= s1_valid &  sel_vc1 & ~bus.VC1_full;
      if (s1_valid && !tgt_full) begin
        bus.vc_data <= bus.Main_data_out;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      pop_count <= '0;
    end else if (next_state == ST_INIT) begin
      pop_count <= '0;
    end else if (bus.Main_rd) begin
      pop_count <= pop_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_main_fifo_reader.sv
// Scoreboard bench for main_fifo_reader: a Main FIFO model feeds the DUT and
// a monitor compares every VC write against the expected word queue.
module tb_main_fifo_reader;
  import main_rd_pkg::*;

  logic       clk;
  logic       reset_L;
  logic       init;
  logic [2:0] state;
  logic       idle;
  logic       error_out;
  logic [7:0] pop_count;

  main_fifo_reader_if #(.BW(6)) bus ();

  main_fifo_reader #(.BW(6), .SEL_BIT(5), .CNT_W(8)) dut (
    .clk       (clk),
    .reset_L   (reset_L),
    .init      (init),
    .bus       (bus),
    .state     (state),
    .idle      (idle),
    .error_out (error_out),
    .pop_count (pop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main FIFO model: data appears the cycle after the pop, empty updates on the pop edge.
  logic [5:0]  mem [0:2047];
  logic [10:0] wr_ptr  = '0;
  logic [10:0] rd_ptr  = '0;
  logic [5:0]  rd_data = '0;

  assign bus.Main_empty    = (wr_ptr == rd_ptr);
  assign bus.Main_data_out = rd_data;

  always @(posedge clk) begin
    if (bus.Main_rd) begin
      rd_data <= mem[rd_ptr];
      rd_ptr  <= rd_ptr + 11'd1;
    end
  end

  logic [6:0]  exp_q [$];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic apply_stimulus(input logic [5:0] w, input bit expect_write);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 11'd1;
    if (expect_write) exp_q.push_back({w[5], w});
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == 3'(ST_IDLE)) break;
    end
    check_output("wait_idle", 32'(state), 32'(ST_IDLE));
  endtask

  task automatic reinit();
    init = 1'b1;
    @(negedge clk);
    check_output("init_state", 32'(state), 32'(ST_INIT));
    check_output("init_pop_count", 32'(pop_count), 32'd0);
    init = 1'b0;
    @(negedge clk);
    check_output("init_to_idle", 32'(state), 32'(ST_IDLE));
  endtask

  always @(negedge clk) begin
    if (reset_L && (bus.VC0_wr || bus.VC1_wr)) begin
      if (exp_q.size() == 0) begin
        check_output("sb_unexpected_write", 32'({bus.VC1_wr, bus.VC0_wr}), 32'd0);
      end else begin
        logic [6:0] e;
        e = exp_q.pop_front();
        check_output("sb_strobe", 32'({bus.VC1_wr, bus.VC0_wr}), e[6] ? 32'd2 : 32'd1);
        check_output("sb_data", 32'(bus.vc_data), 32'(e[5:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wr_cnt;
    reset_L                 = 1'b0;
    init                    = 1'b1;
    bus.Main_error_output   = 1'b0;
    bus.VC0_full            = 1'b0;
    bus.VC0_almost_full     = 1'b0;
    bus.VC1_full            = 1'b0;
    bus.VC1_almost_full     = 1'b0;

    // Reset values and startup sequence
    repeat (2) @(negedge clk);
    check_output("rst_state", 32'(state), 32'(ST_RESET));
    check_output("rst_main_rd", 32'(bus.Main_rd), 32'd0);
    check_output("rst_vc0_wr", 32'(bus.VC0_wr), 32'd0);
    check_output("rst_vc1_wr", 32'(bus.VC1_wr), 32'd0);
    check_output("rst_vc_data", 32'(bus.vc_data), 32'd0);
    check_output("rst_pop_count", 32'(pop_count), 32'd0);
    check_output("rst_idle", 32'(idle), 32'd0);
    check_output("rst_error_out", 32'(error_out), 32'd0);
    #2 reset_L = 1'b1;
    #1 check_output("rel_state", 32'(state), 32'(ST_RESET));
    @(negedge clk);
    check_output("start_init1", 32'(state), 32'(ST_INIT));
    @(negedge clk);
    check_output("start_init2", 32'(state), 32'(ST_INIT));
    init = 1'b0;
    @(negedge clk);
    check_output("start_idle", 32'(state), 32'(ST_IDLE));
    check_output("start_idle_flag", 32'(idle), 32'd1);

    // Routing by class bit, two-cycle latency
    apply_stimulus(6'h05, 1'b1);
    apply_stimulus(6'h25, 1'b1);
    @(negedge clk);
    check_output("route_active", 32'(state), 32'(ST_ACTIVE));
    check_output("route_rd1", 32'(bus.Main_rd), 32'd1);
    @(negedge clk);
    check_output("route_rd2", 32'(bus.Main_rd), 32'd1);
    @(negedge clk);
    check_output("route_rd3", 32'(bus.Main_rd), 32'd0);
    check_output("route_vc0_wr", 32'(bus.VC0_wr), 32'd1);
    check_output("route_data0", 32'(bus.vc_data), 32'h05);
    @(negedge clk);
    check_output("route_vc1_wr", 32'(bus.VC1_wr), 32'd1);
    check_output("route_data1", 32'(bus.vc_data), 32'h25);
    wait_idle(10);
    check_output("route_pop_count", 32'(pop_count), 32'd2);

    // Backpressure mid-burst
    reinit();
    apply_stimulus(6'h11, 1'b1);
    apply_stimulus(6'h32, 1'b1);
    apply_stimulus(6'h03, 1'b1);
    apply_stimulus(6'h24, 1'b1);
    @(negedge clk);
    check_output("bp_rd1", 32'(bus.Main_rd), 32'd1);
    @(negedge clk);
    check_output("bp_rd2", 32'(bus.Main_rd), 32'd1);
    @(negedge clk);
    bus.VC1_almost_full = 1'b1;
    #1 check_output("bp_rd_stop", 32'(bus.Main_rd), 32'd0);
    wr_cnt = int'(bus.VC0_wr | bus.VC1_wr);
    repeat (2) begin
      @(negedge clk);
      check_output("bp_rd_held", 32'(bus.Main_rd), 32'd0);
      wr_cnt += int'(bus.VC0_wr | bus.VC1_wr);
    end
    check_output("bp_inflight_writes", 32'(wr_cnt), 32'd2);
    @(negedge clk);
    bus.VC1_almost_full = 1'b0;
    #1 check_output("bp_rd_resume", 32'(bus.Main_rd), 32'd1);
    wait_idle(20);
    check_output("bp_pop_count", 32'(pop_count), 32'd4);

    // Write into a full VC is dropped and raises an error
    reinit();
    bus.VC0_full = 1'b1;
    apply_stimulus(6'h01, 1'b0);
    @(negedge clk);
    check_output("ovf_rd", 32'(bus.Main_rd), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check_output("ovf_state", 32'(state), 32'(ST_ERROR));
    check_output("ovf_error_out", 32'(error_out), 32'd1);
    check_output("ovf_no_wr", 32'(bus.VC0_wr), 32'd0);
    apply_stimulus(6'h02, 1'b1);
    @(negedge clk);
    check_output("ovf_no_rd", 32'(bus.Main_rd), 32'd0);
    check_output("ovf_sticky", 32'(state), 32'(ST_ERROR));
    bus.VC0_full = 1'b0;
    reinit();
    check_output("ovf_cleared", 32'(error_out), 32'd0);
    wait_idle(20);

    // Upstream error is sticky; the in-flight word still completes
    apply_stimulus(6'h07, 1'b1);
    @(negedge clk);
    check_output("uerr_rd", 32'(bus.Main_rd), 32'd1);
    bus.Main_error_output = 1'b1;
    @(negedge clk);
    check_output("uerr_state", 32'(state), 32'(ST_ERROR));
    bus.Main_error_output = 1'b0;
    @(negedge clk);
    check_output("uerr_inflight_wr", 32'(bus.VC0_wr), 32'd1);
    @(negedge clk);
    check_output("uerr_sticky", 32'(state), 32'(ST_ERROR));
    check_output("uerr_error_out", 32'(error_out), 32'd1);

    // Pop counter wrap
    reinit();
    for (int i = 0; i < 257; i++) apply_stimulus(6'(i), 1'b1);
    wait_idle(400);
    check_output("wrap_pop_count", 32'(pop_count), 32'd1);

    // Asynchronous reset between edges during a burst
    for (int i = 0; i < 10; i++) apply_stimulus(6'h30 + 6'(i), i < 2);
    repeat (4) @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    check_output("arst_state", 32'(state), 32'(ST_RESET));
    check_output("arst_main_rd", 32'(bus.Main_rd), 32'd0);
    check_output("arst_vc0_wr", 32'(bus.VC0_wr), 32'd0);
    check_output("arst_vc1_wr", 32'(bus.VC1_wr), 32'd0);
    check_output("arst_vc_data", 32'(bus.vc_data), 32'd0);
    check_output("arst_pop_count", 32'(pop_count), 32'd0);
    check_output("arst_idle", 32'(idle), 32'd0);
    check_output("arst_error_out", 32'(error_out), 32'd0);
    repeat (2) @(negedge clk);
    check_output("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/main_fifo_reader.md
Name: main_fifo_reader

Overview:
- Consumer side of the Main ingress FIFO in the QoS path: pops words whenever downstream room exists and steers each word to one of two virtual-channel FIFOs (VC0/VC1) by its class bit.
- Owns Main_rd; Main_wr stays with the upstream producer.
- Contains a small control FSM (RESET/INIT/IDLE/ACTIVE/ERROR), a two-stage read/write pipeline and a pop counter.

Parameters:
- BW, 6, word width; must match the Main FIFO width.
- SEL_BIT, BW-1, data bit index that selects the VC: 0 routes to VC0, 1 routes to VC1.
- CNT_W, 8, pop counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous active-low reset.
- init  in  1  synchronous re-initialise request.
- Main_empty  in  1  Main FIFO empty flag.
- Main_error_output  in  1  Main FIFO over/underflow flag.
- Main_data_out  in  BW  Main FIFO read data, valid the cycle after Main_rd.
- Main_rd  out  1  pop strobe to the Main FIFO (combinational).
- VC0_full, VC0_almost_full  in  1 each  VC0 FIFO status.
- VC1_full, VC1_almost_full  in  1 each  VC1 FIFO status.
- VC0_wr, VC1_wr  out  1 each  registered write strobes.
- vc_data  out  BW  registered write data, shared by both VC FIFOs.
- state  out  3  current FSM state.
- idle  out  1  high when state==IDLE.
- error_out  out  1  sticky error flag.
- pop_count  out  CNT_W  total successful pops.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - state=RESET; Main_rd, VC0_wr, VC1_wr, error_out, idle = 0; vc_data=0; pop_count=0; pipeline valid bits cleared.
- State encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Transitions, priority top-down, evaluated each edge:
  - init=1 -> INIT from any state; this also clears error_out.
  - An error condition in any state except RESET/INIT -> ERROR.
  - RESET -> INIT unconditionally on the first edge after reset release.
  - INIT -> IDLE when init=0.
  - IDLE -> ACTIVE when Main_empty=0.
  - ACTIVE -> IDLE when Main_empty=1 and both pipeline stages are empty.
  - ERROR holds until init or reset.
- Error condition: Main_error_output=1, or a stage-2 write targets a VC whose full=1. In the second case that write is suppressed (no strobe) and the word is lost. error_out=1 while in ERROR.
- Pop rule (combinational): Main_rd = (state==ACTIVE) & ~Main_empty & ~VC0_almost_full & ~VC1_almost_full.
  - The destination is unknown before the read, so both VCs must have room.
  - Integration requirement: each VC almost_full must assert with at least 2 free slots, because up to 2 words are in flight.
- Pipeline:
  - Cycle N: Main_rd=1; stage1 valid is set at the edge ending N.
  - Cycle N+1: Main_data_out is captured into vc_data at the edge ending N+1.
  - Cycle N+2: VCx_wr=1 for exactly one cycle, x = captured data[SEL_BIT].
  - Latency from Main_rd to VCx_wr is exactly 2 cycles; back-to-back pops give back-to-back writes (1 word/cycle).
- In-flight words complete their writes in every state except RESET; entering INIT or ERROR only stops new pops.
- VC0_wr and VC1_wr are never high in the same cycle. vc_data holds its last value when no write is strobed.
- pop_count increments by 1 on each cycle with Main_rd=1. It wraps from 2^CNT_W-1 to 0, is cleared by reset and by entry into INIT.
- Simultaneous events:
  - init wins over a same-cycle error condition.
  - A pop stops immediately (combinationally) when almost_full rises, even mid-burst.
- Main_empty is used as-is; the Main FIFO updates empty on the same edge as the pop, so no extra gap is inserted when one entry remains.

Decomposition:
- Shared package main_rd_pkg holds:
  - State encodings ST_RESET..ST_ERROR (3-bit).
  - The default CNT_W.
- The block is a single module; the two pipeline stages are too small to justify a sub-module.

Test Plan:
- Reset/init: release reset_L with init=1 for 2 cycles -> state 0, then 1, then 2 after init drops; all outputs 0.
- Routing: preload Main with 6'h05, 6'h25 (bit5 = 0, 1) and both VCs empty.
  - Main_rd high for 2 consecutive cycles.
  - VC0_wr with vc_data=6'h05 at N+2, VC1_wr with 6'h25 at N+3; pop_count=2; state returns to IDLE.
- Backpressure: assert VC1_almost_full mid-burst of 4 words.
  - Main_rd drops that same cycle; at most 2 more writes complete.
  - Pops resume the cycle after almost_full clears; pop_count ends at 4.
- Overflow error: hold VC0_full=1 with almost_full=0 and pop 6'h01.
  - No VC0_wr; state=4 and error_out=1 at the write cycle; no further Main_rd.
  - init pulse clears to INIT then IDLE with pop_count=0.
- Upstream error: Main_error_output=1 for 1 cycle in ACTIVE -> ERROR, sticky after the input clears.
- Wrap and async reset: with CNT_W=8, perform 257 pops -> pop_count=1. Then drop reset_L mid-burst, asynchronously between edges -> all outputs 0 immediately.
